clk_div_prog: RTL

Runtime-programmable clock-enable divider. Generates a divided clock-like output with a programmable period and high time, plus a one-cycle tick at each period start. New settings arrive over a valid/ready handshake and are applied glitch-free at period boundaries. It is used by the image pipeline to pace pixel, line and sensor-timing domains from the single system clock.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/clk_div_prog.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and clamp helpers for the programmable clock-enable divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    // Helpers work on a wide container so any field width up to 64 bits fits.
    localparam int CLAMP_W = 64;

    // A zero period is meaningless, so the smallest legal period is one cycle.
    function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] div);
        if (div == '0) begin
            return {{(CLAMP_W-1){1'b0}}, 1'b1};
        end
        return div;
    endfunction

    // High time can never exceed the (already clamped) period.
    function automatic logic [CLAMP_W-1:0] clamp_high(input logic [CLAMP_W-1:0] high,
                                                      input logic [CLAMP_W-1:0] div);
        if (high > div) begin
            return div;
        end
        return high;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock-enable divider with shadowed configuration that
// is only applied at period boundaries (or immediately while idle).
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_HIGH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             resync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    div_state_t       state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] active_n, active_n_nx;
    logic [WIDTH-1:0] active_h, active_h_nx;
    logic [WIDTH-1:0] shadow_n, shadow_n_nx;
    logic [WIDTH-1:0] shadow_h, shadow_h_nx;
    logic             pending, pending_nx;
    logic             clk_out_nx, tick_nx;

    logic [WIDTH-1:0] clamped_n, clamped_h;
    logic [WIDTH-1:0] eff_n, eff_h;
    logic [WIDTH-1:0] cnt_inc;
    logic             capture;

    assign cfg_ready = !pending;
    assign running   = (state == RUN);
    assign capture   = cfg_valid && !pending;
    assign cnt_inc   = cnt + ONE;

    // Clamp the requested fields on their way into the shadow registers.
    always_comb begin
        clamped_n = WIDTH'(clamp_div(CLAMP_W'(cfg_div)));
        clamped_h = WIDTH'(clamp_high(CLAMP_W'(cfg_high), CLAMP_W'(clamped_n)));
    end

    // Values that a period start would use: the shadow wins when a load is due.
    always_comb begin
        eff_n = active_n;
        eff_h = active_h;
        if (pending) begin
            eff_n = shadow_n;
            eff_h = shadow_h;
        end
    end

    // Next-state, counter, output and configuration-bookkeeping decisions.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        clk_out_nx  = clk_out;
        tick_nx     = tick;
        active_n_nx = active_n;
        active_h_nx = active_h;
        shadow_n_nx = shadow_n;
        shadow_h_nx = shadow_h;
        pending_nx  = pending;

        case (state)
            IDLE: begin
                cnt_nx     = '0;
                clk_out_nx = 1'b0;
                tick_nx    = 1'b0;
                if (pending) begin
                    active_n_nx = eff_n;
                    active_h_nx = eff_h;
                    pending_nx  = 1'b0;
                end
                if (en) begin
                    state_nx   = RUN;
                    tick_nx    = 1'b1;
                    clk_out_nx = (eff_h != '0);
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    clk_out_nx = 1'b0;
                    tick_nx    = 1'b0;
                end else if (resync || (cnt == active_n - ONE)) begin
                    if (pending) begin
                        active_n_nx = eff_n;
                        active_h_nx = eff_h;
                        pending_nx  = 1'b0;
                    end
                    cnt_nx     = '0;
                    tick_nx    = 1'b1;
                    clk_out_nx = (eff_h != '0);
                end else begin
                    cnt_nx     = cnt_inc;
                    clk_out_nx = (cnt_inc < active_h);
                    tick_nx    = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A load and a capture never coincide: capture needs pending low,
        // a load needs it high.
        if (capture) begin
            shadow_n_nx = clamped_n;
            shadow_h_nx = clamped_h;
            pending_nx  = 1'b1;
        end
    end

    // State, counter, active/shadow configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            active_n <= WIDTH'(DEFAULT_DIV);
            active_h <= WIDTH'(DEFAULT_HIGH);
            shadow_n <= '0;
            shadow_h <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            clk_out  <= clk_out_nx;
            tick     <= tick_nx;
            active_n <= active_n_nx;
            active_h <= active_h_nx;
            shadow_n <= shadow_n_nx;
            shadow_h <= shadow_h_nx;
            pending  <= pending_nx;
        end
    end

endmodule
